// File: rtl/life_pkg.sv
// life_pkg: loader states, tile ids and the 8x8 grid to 4x4 tile-word packing.
package life_pkg;
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, VERIFY, DONE} state_e;
  localparam logic [1:0] TILE_NW = 2'd0;
  localparam logic [1:0] TILE_SW = 2'd1;
  localparam logic [1:0] TILE_NE = 2'd2;
  localparam logic [1:0] TILE_SE = 2'd3;
  // grid holds row r in bits [r*8 +: 8], with column 0 in the MSB of that byte
  function automatic logic [15:0] tile_pack(input logic [63:0] grid, input logic [1:0] sel);
    logic [15:0] w;
    int rb;
    int cb;
    w = '0;
    rb = (sel == TILE_SW || sel == TILE_SE) ? 4 : 0;
    cb = (sel == TILE_NE || sel == TILE_SE) ? 4 : 0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        w[c*4+r] = grid[(rb + r)*8 + 7 - cb - c];
    return w;
  endfunction
endpackage

// File: rtl/life_step_timer.sv
// life_step_timer: registered one-cycle step pulse every STEP_DIV enabled cycles.
module life_step_timer #(
  parameter int STEP_DIV = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic step
);
  localparam int CW = $clog2(STEP_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  logic step_q, step_d, wrap;
  always_comb begin
    wrap = cnt_q == CW'(STEP_DIV - 1);
    cnt_d = (en && !wrap) ? cnt_q + 1'b1 : '0;
    step_d = en && wrap;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      step_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      step_q <= step_d;
    end
  end
  assign step = step_q;
endmodule

// File: rtl/life_pattern_loader.sv
// life_pattern_loader: packs an 8-row byte stream into four tile writes and paces step.
// Define LIFE_LOADER_VERIFY_EN to add a 4-cycle readback compare after the writes.
module life_pattern_loader
  import life_pkg::*;
#(
  parameter int STEP_DIV = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic        run,
  output logic [15:0] vali,
  output logic [1:0]  vali_selector,
  output logic        write_enb,
  output logic        step,
  output logic        load_done,
  input  logic [15:0] valo,
  output logic [1:0]  valo_selector,
  output logic        verify_err
);
  state_e state_q, state_d;
  logic [2:0] row_q, row_d;
  logic [63:0] shadow_q, shadow_d;
  logic [1:0] idx_q, idx_d;
  logic byte_ready_q, byte_ready_d;
  logic write_enb_q, write_enb_d;
  logic [15:0] vali_q, vali_d;
  logic [1:0] vali_selector_q, vali_selector_d;
  logic load_done_q, load_done_d;
  logic [1:0] valo_selector_q, valo_selector_d;
  logic verify_err_q, verify_err_d;
  logic accept, timer_en;
`ifndef LIFE_LOADER_VERIFY_EN
  logic unused_valo;
  assign unused_valo = ^valo;
`endif
  always_comb begin
    accept = byte_valid && byte_ready_q;
    state_d = state_q;
    row_d = row_q;
    shadow_d = shadow_q;
    idx_d = idx_q;
    verify_err_d = verify_err_q;
    case (state_q)
      IDLE, COLLECT: if (accept) begin
        shadow_d[{row_q, 3'b000} +: 8] = byte_in;
        row_d = row_q + 3'd1;
        state_d = (row_q == 3'd7) ? WRITE : COLLECT;
        idx_d = TILE_NW;
        if (state_q == IDLE) verify_err_d = 1'b0;
      end
      WRITE: begin
        idx_d = idx_q + 2'd1;
`ifdef LIFE_LOADER_VERIFY_EN
        if (idx_q == TILE_SE) state_d = VERIFY;
`else
        if (idx_q == TILE_SE) state_d = DONE;
`endif
      end
`ifdef LIFE_LOADER_VERIFY_EN
      VERIFY: begin
        idx_d = idx_q + 2'd1;
        if (valo != tile_pack(shadow_q, idx_q)) verify_err_d = 1'b1;
        if (idx_q == TILE_SE) state_d = DONE;
      end
`endif
      DONE: begin
        state_d = IDLE;
        row_d = '0;
      end
      default: state_d = IDLE;
    endcase
    // outputs are registered from the next state so they line up with it
    byte_ready_d = state_d == IDLE || state_d == COLLECT;
    write_enb_d = state_d == WRITE;
    vali_selector_d = write_enb_d ? idx_d : '0;
    vali_d = write_enb_d ? tile_pack(shadow_d, idx_d) : '0;
    load_done_d = state_d == DONE;
    valo_selector_d = (state_d == VERIFY) ? idx_d : '0;
    timer_en = run && state_d == IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      row_q <= '0;
      shadow_q <= '0;
      idx_q <= '0;
      byte_ready_q <= 1'b1;
      write_enb_q <= 1'b0;
      vali_q <= '0;
      vali_selector_q <= '0;
      load_done_q <= 1'b0;
      valo_selector_q <= '0;
      verify_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      shadow_q <= shadow_d;
      idx_q <= idx_d;
      byte_ready_q <= byte_ready_d;
      write_enb_q <= write_enb_d;
      vali_q <= vali_d;
      vali_selector_q <= vali_selector_d;
      load_done_q <= load_done_d;
      valo_selector_q <= valo_selector_d;
      verify_err_q <= verify_err_d;
    end
  end
  life_step_timer #(.STEP_DIV(STEP_DIV)) u_timer (
    .clk(clk),
    .reset(reset),
    .en(timer_en),
    .step(step)
  );
  assign byte_ready = byte_ready_q;
  assign write_enb = write_enb_q;
  assign vali = vali_q;
  assign vali_selector = vali_selector_q;
  assign load_done = load_done_q;
  assign valo_selector = valo_selector_q;
  assign verify_err = verify_err_q;
endmodule

// File: doc/life_pattern_loader.md
Name: life_pattern_loader

Overview:
- Write-side master for the 8x8 life array: accepts an 8-row pattern as a byte stream, packs it into the four 4x4 tile words and drives the array's vali/vali_selector/write_enb port.
- Also owns generation timing: produces the array's step pulse at a programmable rate, and holds step low while a pattern is being loaded.
- Sits between the pattern source (UART/switch front end) and the 8x8 array.

Parameters:
- STEP_DIV, 25000000, clock cycles between step pulses while running; legal range is 2 or more.
- CW, $clog2(STEP_DIV), width of the step counter; derived, not overridden.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- byte_in  in  8  one grid row; bit 7 = column 0 (west), bit 0 = column 7
- byte_valid  in  1  byte_in valid
- byte_ready  out  1  loader accepts a byte this cycle
- run  in  1  level; enables step generation
- vali  out  16  tile word to the array
- vali_selector  out  2  target tile: 0=NW, 1=SW, 2=NE, 3=SE
- write_enb  out  1  tile write strobe
- step  out  1  one-cycle generation pulse
- load_done  out  1  one-cycle pulse after the last tile write
- valo  in  16  array readback (used only with the optional feature)
- valo_selector  out  2  readback tile select (held 0 without the optional feature)
- verify_err  out  1  sticky readback-mismatch flag (held 0 without the optional feature)

Behaviour:
- Reset (reset==0 at a clk edge) sets:
  - state IDLE; row count 0; 64-bit shadow cleared; step counter 0;
  - all outputs 0, except byte_ready=1.
- Rows: row 0 = north. Tiles are: tile 0 = rows 0-3, cols 0-3; tile 1 = rows 4-7, cols 0-3; tile 2 = rows 0-3, cols 4-7; tile 3 = rows 4-7, cols 4-7.
- Cell (r,c) local to its tile maps to tile-word bit c*4+r. Bits 0-3 form the west column; bits 3,7,11,15 form the south row.
- FSM states: IDLE, COLLECT, WRITE, VERIFY (optional), DONE.
- IDLE / COLLECT:
  - byte_ready=1. A byte is accepted when byte_valid & byte_ready, and stored as the row at the current row count.
  - The first accepted byte moves IDLE to COLLECT.
  - Accepting the 8th byte (row 7) moves to WRITE. byte_ready drops to 0 in the following cycle.
- WRITE: exactly 4 consecutive cycles.
  - write_enb=1; vali_selector=0,1,2,3 in order; vali = packed shadow tile for that selector.
  - After the 4th cycle: go to VERIFY if the optional feature is compiled in, otherwise to DONE.
- DONE: lasts one cycle; load_done=1; then IDLE with row count 0.
- Step generator:
  - The counter increments while run==1 and state==IDLE.
  - When the counter reaches STEP_DIV-1: step=1 for that cycle and the counter returns to 0.
  - Leaving IDLE or deasserting run clears the counter to 0. step is never 1 outside IDLE.
- Latencies:
  - 8th byte accepted -> first write_enb on the next cycle.
  - 8th byte -> load_done 5 cycles later (9 cycles with verify).
- Boundary conditions:
  - byte_valid while in WRITE/VERIFY/DONE is ignored; the byte is not consumed.
  - Reset asserted mid-load discards partial rows. No write_enb is issued after a reset, even mid-WRITE.
  - run asserted during a load has no effect until return to IDLE; the count starts from 0 at that point.

Optional Feature:
- Macro: LIFE_LOADER_VERIFY_EN.
- Defined:
  - VERIFY state lasts 4 cycles and drives valo_selector=0..3, each paired with a compare of valo (combinational, same-cycle) against the shadow tile.
  - Any mismatch sets verify_err. verify_err clears only on reset or on the first byte of a new load.
- Undefined:
  - No VERIFY state; valo is unused; valo_selector=0; verify_err=0.

Decomposition:
- Shared package life_pkg holds:
  - state enum;
  - TILE_NW/SW/NE/SE = 0/1/2/3;
  - function tile_pack(64-bit grid, 2-bit sel) -> 16-bit word.
- One natural sub-module: life_step_timer (counter, run/enable in, step out), parameterised by STEP_DIV.

Test Plan:
- Glider 0x40,0x20,0xE0, then 0x00 x5 -> WRITE cycles produce vali = 0x0654, 0x0000, 0x0000, 0x0000 on selectors 0..3; load_done 5 cycles after the 8th byte.
- Rows 0x00 x7 then 0x01 -> tile 3 word 0x8000; row0=0x80 with others 0 -> tile 0 word 0x0001; row0=0x08 -> tile 2 word 0x0001.
- STEP_DIV=4, run=1 in IDLE -> step high for 1 cycle every 4 cycles, first pulse 4 cycles after run rises; a byte arriving mid-count suppresses step until DONE and restarts the count.
- Byte stream with byte_valid gaps, plus byte_valid held during WRITE -> exactly 8 bytes consumed; byte_ready low for WRITE..DONE.
- reset low after 5 bytes, then a full 8-byte load -> no write_enb from the aborted load; writes reflect only the new 8 bytes.
- With LIFE_LOADER_VERIFY_EN: model returns valo with bit 0 flipped on tile 2 -> verify_err=1 after VERIFY; next load's first byte clears it.
